host_cmd_ctrl: RTL and testbench

HOST_CMD_CTRL -- requirements
Module: host_cmd_ctrl

---
 rtl/host_cmd_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_host_cmd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_ctrl.sv
// Byte-stream host command controller: decodes WR/RD/STEP/RST frames from a
// receive strobe, drives a simple memory port and CPU run/reset, and replies over a tx handshake.
module host_cmd_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STEP_W  = 16,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  output logic              cpu_reset,
  output logic              rx_overrun,
  output logic              err_timeout
);

  localparam int NA   = ADDR_W / 8;
  localparam int ND   = DATA_W / 8;
  localparam int NS   = STEP_W / 8;
  localparam int BC_W = 8;
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] GET_ADDR = 4'd1;
  localparam logic [3:0] GET_DATA = 4'd2;
  localparam logic [3:0] GET_CNT  = 4'd3;
  localparam logic [3:0] MEM_WR   = 4'd4;
  localparam logic [3:0] MEM_RD   = 4'd5;
  localparam logic [3:0] RD_WAIT  = 4'd6;
  localparam logic [3:0] SEND     = 4'd7;
  localparam logic [3:0] STEP     = 4'd8;
  localparam logic [3:0] CPU_RST  = 4'd9;
  localparam logic [3:0] ACK      = 4'd10;
  localparam logic [3:0] ERR      = 4'd11;

  logic [3:0]        state;
  logic              is_wr;
  logic [BC_W-1:0]   byte_cnt;
  logic [TM_W-1:0]   timer;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] rd_r;
  logic [STEP_W-1:0] cnt_r;
  logic [ADDR_W+7:0] addr_sh;
  logic [DATA_W+7:0] data_sh;
  logic [STEP_W+7:0] cnt_sh;
  logic              in_get;

  // Little-endian fields: each new byte enters at the top and earlier bytes move down.
  always_comb begin
    addr_sh = {rx_data, addr_r} >> 8;
    data_sh = {rx_data, data_r} >> 8;
    cnt_sh  = {rx_data, cnt_r} >> 8;
    in_get  = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CNT);
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = data_r;
  assign mem_we    = (state == MEM_WR);
  assign mem_re    = (state == MEM_RD);
  assign cpu_run   = (state == STEP);
  assign cpu_reset = (state == CPU_RST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      byte_cnt    <= '0;
      timer       <= '0;
      rst_cnt     <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      rd_r        <= '0;
      cnt_r       <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (rx_valid && (state != IDLE) && !in_get)
        rx_overrun <= 1'b1;

      // Inter-byte watchdog; only fires in cycles without rx_valid.
      if (in_get) begin
        if (rx_valid)
          timer <= '0;
        else if (timer == TM_W'(TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
          state       <= IDLE;
        end else
          timer <= timer + 1'b1;
      end

      case (state)
        IDLE: if (rx_valid) begin
          byte_cnt <= '0;
          timer    <= '0;
          rst_cnt  <= '0;
          is_wr    <= (rx_data == 8'h01);
          case (rx_data)
            8'h01, 8'h02: state <= GET_ADDR;
            8'h03:        state <= GET_CNT;
            8'h04:        state <= CPU_RST;
            default:      state <= ERR;
          endcase
        end
        GET_ADDR: if (rx_valid) begin
          addr_r <= addr_sh[ADDR_W-1:0];
          if (byte_cnt == BC_W'(NA - 1)) begin
            byte_cnt <= '0;
            state    <= is_wr ? GET_DATA : MEM_RD;
          end else
            byte_cnt <= byte_cnt + 1'b1;
        end
        GET_DATA: if (rx_valid) begin
          data_r <= data_sh[DATA_W-1:0];
          if (byte_cnt == BC_W'(ND - 1)) begin
            byte_cnt <= '0;
            state    <= MEM_WR;
          end else
            byte_cnt <= byte_cnt + 1'b1;
        end
        GET_CNT: if (rx_valid) begin
          cnt_r <= cnt_sh[STEP_W-1:0];
          if (byte_cnt == BC_W'(NS - 1)) begin
            byte_cnt <= '0;
            state    <= (cnt_sh[STEP_W-1:0] == '0) ? ACK : STEP;
          end else
            byte_cnt <= byte_cnt + 1'b1;
        end
        MEM_WR:  state <= ACK;
        MEM_RD:  state <= RD_WAIT;
        RD_WAIT: begin
          rd_r     <= mem_rdata;
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (!tx_valid) begin
            tx_data  <= rd_r[7:0];
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            rd_r     <= rd_r >> 8;
            if (byte_cnt == BC_W'(ND - 1))
              state <= IDLE;
            else
              byte_cnt <= byte_cnt + 1'b1;
          end
        end
        // Counter holds the remaining run cycles including the current one.
        STEP: begin
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == STEP_W'(1))
            state <= ACK;
        end
        CPU_RST: begin
          if (rst_cnt == RC_W'(RST_CYC - 1))
            state <= ACK;
          else
            rst_cnt <= rst_cnt + 1'b1;
        end
        ACK, ERR: begin
          if (!tx_valid) begin
            tx_data  <= (state == ACK) ? 8'hA5 : 8'hEE;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Directed bench for host_cmd_ctrl: table of command frames plus hand-written
// sequences for timeout, tx back-pressure with overrun, and reset during STEP.
module tb_host_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        cpu_run;
  logic        cpu_reset;
  logic        rx_overrun;
  logic        err_timeout;

  localparam logic [31:0] RD_VAL = 32'hDEADBEEF;

  host_cmd_ctrl #(
    .ADDR_W(32), .DATA_W(32), .STEP_W(16), .RST_CYC(4), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .cpu_reset(cpu_reset),
    .rx_overrun(rx_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Observed activity, accumulated at the falling edge.
  int          we_n = 0, re_n = 0, run_n = 0, rst_n = 0, both_n = 0, to_n = 0;
  logic [31:0] we_addr = '0, we_data = '0;
  logic [7:0]  tx_q[$];
  bit          re_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      we_n++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (mem_re) re_n++;
    if (cpu_run) run_n++;
    if (cpu_reset) rst_n++;
    if (cpu_run && cpu_reset) both_n++;
    if (err_timeout) to_n++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    mem_rdata = re_prev ? RD_VAL : 32'h0;
    re_prev   = mem_re;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int nb, input logic [71:0] bytes);
    for (int i = 0; i < nb; i++) begin
      rx_data  = bytes[i*8 +: 8];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          nb;
    logic [71:0] rx;
    int          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          re;
    int          run;
    int          rst;
    int          ntx;
    logic [31:0] tx;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int b_we, b_re, b_run, b_rst, b_both, q0, got;
    b_we = we_n; b_re = re_n; b_run = run_n; b_rst = rst_n; b_both = both_n;
    q0 = tx_q.size();
    send(v.nb, v.rx);
    for (int c = 0; c < 2000 && (tx_q.size() - q0) < v.ntx; c++) tick();
    repeat (8) tick();
    got = tx_q.size() - q0;
    chk({v.name, "_we"}, we_n - b_we, v.we);
    if (v.we > 0) begin
      chk({v.name, "_addr"}, we_addr, v.addr);
      chk({v.name, "_wdata"}, we_data, v.wdata);
    end
    chk({v.name, "_re"}, re_n - b_re, v.re);
    chk({v.name, "_run"}, run_n - b_run, v.run);
    chk({v.name, "_rst"}, rst_n - b_rst, v.rst);
    chk({v.name, "_overlap"}, both_n - b_both, 0);
    chk({v.name, "_ntx"}, got, v.ntx);
    for (int j = 0; j < v.ntx && j < got; j++)
      chk($sformatf("%s_tx%0d", v.name, j), tx_q[q0 + j], v.tx[j*8 +: 8]);
  endtask

  initial begin
    int          c, bad, q0, b_run;
    logic [7:0]  held;

    vecs[0] = '{"wr",     9, 72'hDEADBEEF_00000010_01, 1, 32'h10,       32'hDEADBEEF, 0, 0,   0, 1, 32'hA5};
    vecs[1] = '{"rd",     5, 72'h00000010_02,          0, 32'h0,        32'h0,        1, 0,   0, 4, 32'hDEADBEEF};
    vecs[2] = '{"step5",  3, 72'h0005_03,              0, 32'h0,        32'h0,        0, 5,   0, 1, 32'hA5};
    vecs[3] = '{"step0",  3, 72'h0000_03,              0, 32'h0,        32'h0,        0, 0,   0, 1, 32'hA5};
    vecs[4] = '{"badop",  1, 72'h7F,                   0, 32'h0,        32'h0,        0, 0,   0, 1, 32'hEE};
    vecs[5] = '{"rst",    1, 72'h04,                   0, 32'h0,        32'h0,        0, 0,   4, 1, 32'hA5};
    vecs[6] = '{"step256",3, 72'h0100_03,              0, 32'h0,        32'h0,        0, 256, 0, 1, 32'hA5};
    vecs[7] = '{"wrmax",  9, 72'h00000001_FFFFFFFF_01, 1, 32'hFFFFFFFF, 32'h1,        0, 0,   0, 1, 32'hA5};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu", {cpu_run, cpu_reset}, 0);
    chk("rst_flags", {rx_overrun, err_timeout}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("overrun_clean", rx_overrun, 0);

    // Truncated RD frame, then silence.
    q0 = tx_q.size();
    send(3, 72'h0010_02);
    c = 0;
    while (c < 200) begin
      tick();
      c++;
      if (err_timeout) break;
    end
    chk("to_cycle", c, 50);
    tick();
    chk("to_width", err_timeout, 0);
    repeat (5) tick();
    chk("to_no_tx", tx_q.size() - q0, 0);
    run_vec(vecs[1]);

    // Back-pressure during SEND with a stray byte arriving.
    tx_ready = 1'b0;
    q0 = tx_q.size();
    send(5, 72'h00000010_02);
    c = 0;
    while (!tx_valid && c < 20) begin
      tick();
      c++;
    end
    held = tx_data;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) begin rx_data = 8'h55; rx_valid = 1'b1; end
      if (i == 6) rx_valid = 1'b0;
      @(negedge clk);
      if (!tx_valid || tx_data !== held) bad++;
    end
    chk("stall_first", held, 8'hEF);
    chk("stall_stable", bad, 0);
    chk("stall_no_tx", tx_q.size() - q0, 0);
    chk("stall_overrun", rx_overrun, 1);
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 100 && (tx_q.size() - q0) < 4; i++) tick();
    repeat (8) tick();
    chk("stall_ntx", tx_q.size() - q0, 4);
    if (tx_q.size() - q0 >= 4)
      chk("stall_bytes", {tx_q[q0+3], tx_q[q0+2], tx_q[q0+1], tx_q[q0]}, RD_VAL);

    // Reset in the middle of a long STEP.
    send(3, 72'h0100_03);
    repeat (10) tick();
    chk("step_running", cpu_run, 1);
    reset = 1'b1;
    tick();
    chk("abort_run", cpu_run, 0);
    chk("abort_tx", tx_valid, 0);
    chk("abort_overrun", rx_overrun, 0);
    reset = 1'b0;
    q0 = tx_q.size();
    b_run = run_n;
    repeat (300) tick();
    chk("abort_quiet_tx", tx_q.size() - q0, 0);
    chk("abort_quiet_run", run_n - b_run, 0);
    chk("timeout_total", to_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
